// File: rtl/lzc_pkg.sv
// Shared definitions for the leading-zero normalizer family: count width helper,
// pipeline latency and the normalized-result record.
`ifndef LZC_RESULT_T
`define LZC_RESULT_T(W, C) struct packed { logic [(W)-1:0] data; logic [(C)-1:0] cnt; logic zero; }
`endif

package lzc_pkg;

    localparam int LZC_NORM_LATENCY = 3;

    // Width needed to represent every count 0..size inclusive.
    function automatic int lzc_out_size(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/lzc_normalize_norm_shifter.sv
// Registered left barrel shifter with load enable; the final normalization stage.
// Any shift of SIZE or more yields an all-zero word.
module norm_shifter #(
    parameter int SIZE   = 64,
    parameter int CNT_W  = 7,
    parameter     FAMILY = "Stratix 10"
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             en,
    input  logic [SIZE-1:0]  din,
    input  logic [CNT_W-1:0] cnt,
    output logic [SIZE-1:0]  dout
);

    logic [SIZE-1:0] shift_s;

    if (FAMILY == "generic") begin : g_behav
        assign shift_s = (cnt >= CNT_W'(SIZE)) ? {SIZE{1'b0}} : (din << cnt);
    end else begin : g_tree
        // One mux level per count bit; level k shifts by 2^k.
        logic [SIZE-1:0] lvl_s [0:CNT_W];
        assign lvl_s[0] = din;
        for (genvar k = 0; k < CNT_W; k++) begin : g_lvl
            localparam int SH = 1 << k;
            if (SH >= SIZE) begin : g_flush
                assign lvl_s[k+1] = cnt[k] ? {SIZE{1'b0}} : lvl_s[k];
            end else begin : g_shift
                assign lvl_s[k+1] = cnt[k] ? {lvl_s[k][SIZE-1-SH:0], {SH{1'b0}}} : lvl_s[k];
            end
        end
        assign shift_s = lvl_s[CNT_W];
    end

    // Output register; holds its value while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (sclr) begin
            dout <= {SIZE{1'b0}};
        end else if (en) begin
            dout <= shift_s;
        end
    end

endmodule

// File: rtl/lzc_normalize.sv
// Three-stage left normalizer: capture, leading-zero count, shift. A single
// enable (downstream free or output empty) advances or freezes every stage.
module lzc_normalize
    import lzc_pkg::*;
#(
    parameter int SIZE     = 64,
    parameter int OUT_SIZE = lzc_out_size(SIZE),
    parameter     FAMILY   = "Stratix 10"
) (
    input  logic                clk,
    input  logic                sclr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIZE-1:0]     out_data,
    output logic [OUT_SIZE-1:0] out_cnt,
    output logic                out_zero
);

    typedef `LZC_RESULT_T(SIZE, OUT_SIZE) result_t;

    logic                en_s;
    logic                v1_r;
    logic                v2_r;
    logic                v3_r;
    logic [SIZE-1:0]     data1_r;
    logic [SIZE-1:0]     data2_r;
    logic [OUT_SIZE-1:0] cnt_s;
    logic [OUT_SIZE-1:0] cnt2_r;
    logic [OUT_SIZE-1:0] cnt3_r;
    logic                zero3_r;
    logic [SIZE-1:0]     shifted_s;
    result_t             result_s;

    assign en_s     = ~v3_r | out_ready;
    assign in_ready = en_s;

    // Stage 1: capture the raw word.
    always_ff @(posedge clk) begin
        if (sclr) begin
            v1_r    <= 1'b0;
            data1_r <= {SIZE{1'b0}};
        end else if (en_s) begin
            v1_r    <= in_valid;
            data1_r <= in_data;
        end
    end

    // Leading-zero count: the last hit scanning upward is the highest set bit.
    always_comb begin
        cnt_s = OUT_SIZE'(SIZE);
        for (int i = 0; i < SIZE; i++) begin
            cnt_s = data1_r[i] ? OUT_SIZE'(SIZE - 1 - i) : cnt_s;
        end
    end

    // Stage 2: register count alongside the word.
    always_ff @(posedge clk) begin
        if (sclr) begin
            v2_r    <= 1'b0;
            data2_r <= {SIZE{1'b0}};
            cnt2_r  <= {OUT_SIZE{1'b0}};
        end else if (en_s) begin
            v2_r    <= v1_r;
            data2_r <= data1_r;
            cnt2_r  <= cnt_s;
        end
    end

    norm_shifter #(
        .SIZE   (SIZE),
        .CNT_W  (OUT_SIZE),
        .FAMILY (FAMILY)
    ) u_shift (
        .clk  (clk),
        .sclr (sclr),
        .en   (en_s),
        .din  (data2_r),
        .cnt  (cnt2_r),
        .dout (shifted_s)
    );

    // Stage 3: count and zero flag travel with the shifted word.
    always_ff @(posedge clk) begin
        if (sclr) begin
            v3_r    <= 1'b0;
            cnt3_r  <= {OUT_SIZE{1'b0}};
            zero3_r <= 1'b0;
        end else if (en_s) begin
            v3_r    <= v2_r;
            cnt3_r  <= cnt2_r;
            zero3_r <= (cnt2_r == OUT_SIZE'(SIZE));
        end
    end

    // Assemble the registered stage-3 fields into the result record.
    always_comb begin
        result_s      = '0;
        result_s.data = shifted_s;
        result_s.cnt  = cnt3_r;
        result_s.zero = zero3_r;
    end

    assign out_valid = v3_r;
    assign out_data  = result_s.data;
    assign out_cnt   = result_s.cnt;
    assign out_zero  = result_s.zero;

endmodule
